pipe_exe_muldiv: RTL and testbench
==================================

# pipe_exe_muldiv

Parametrised execute-stage multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU path in the EXE stage. It accepts one operation at a time from ID through the valid/allowin handshake and holds the stage for multi-cycle work: a pipelined multiplier or an iterative divider. It commits HI/LO only when the operation leaves toward MEM unflushed and exception-free.

## Interface
- WIDTH, 32, operand/HI/LO width (≥ 8, even)
- MUL_LAT, 2, cycles a multiply occupies the stage (≥ 1)

- clk  in  1  clock
- rst  in  1  reset (rst, synchronous, active-high; clock clk)
- in_valid  in  1  ID presents an op (id_exe_validto)
- allowin  out  1  stage accepts an op this cycle
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
- a, b  in  WIDTH  rs, rt operands (b used only by mul/div)
- ex_block  in  1  exception in this or a later stage: suppress HI/LO commit
- flush  in  1  kill resident op
- mem_allowin  in  1  MEM can accept
- out_valid  out  1  op complete and offered to MEM
- busy  out  1  mul/div in progress (not yet complete)
- hi, lo  out  WIDTH  architectural HI/LO

## Operation
- States: IDLE (empty), MUL (counter), DIV (counter), DONE (result held, out_valid=1).
- allowin = !valid || (done && mem_allowin), forced 0 while flush=1.
- Accept on in_valid && allowin: latch op, a, b. NOP/MTHI/MTLO → DONE. MULT/MULTU → MUL. DIV/DIVU → DIV.
- MUL: product registered through MUL_LAT stages; MULT signed, MULTU unsigned; 2·WIDTH-bit product, hi = upper, lo = lower.
- DIV: restoring, unsigned magnitudes, one quotient bit per cycle for WIDTH cycles, then one sign-fix cycle. Signed: quotient negative iff signs differ; remainder takes the dividend's sign.
- Divide by zero (b=0): lo = all ones, hi = a, for both DIV and DIVU.
- DIV of MIN by −1: lo = MIN, hi = 0 (natural wrap).
- MTHI: hi ← a. MTLO: lo ← a. NOP: no HI/LO change.
- Commit: at the edge where out_valid && mem_allowin && !flush. HI/LO are written if the op writes them and ex_block=0. The state then goes to IDLE, or to the new op's state if one is accepted the same edge.
- flush: at the next edge, valid←0, state←IDLE, no commit, divider/multiplier results discarded. flush outranks both commit and acceptance.
- ex_block=1 at the commit edge: the op still retires (out_valid handshake completes) but HI/LO are unchanged.

## Timing
- Reset values: state IDLE, allowin=1, out_valid=0, busy=0, hi=0, lo=0, internal counters 0.
- Latency from accept edge to out_valid=1:
  - NOP/MTHI/MTLO: 0 cycles (out_valid in the cycle after accept).
  - MUL: MUL_LAT cycles.
  - DIV: WIDTH+1 cycles.
- busy=1 exactly during MUL/DIV states; allowin=0 throughout busy.
- out_valid remains asserted with stable hi/lo inputs while mem_allowin=0; there is no timeout.
- Back-to-back: a new op is accepted on the same edge as a commit. With mem_allowin=1, a MTLO stream sustains 1 op/cycle.
- hi/lo change only at commit edges (or reset). New values are visible the cycle after commit.
- Reset mid-operation: all state aborts, HI/LO are cleared.

## Test plan
- Reset, then MULT a=−3 (FFFFFFFD), b=5, MUL_LAT=2 → out_valid 2 cycles after accept, busy for 2 cycles; after commit hi=FFFFFFFF, lo=FFFFFFF1. MULTU with same operands → hi=00000004, lo=FFFFFFF1.
- DIVU 100/7 → allowin=0 for 33 cycles, then hi=2, lo=14. DIV −7/2 → lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- DIV 1234/0 → lo=FFFFFFFF, hi=00001234. DIVU 0/0 → lo=FFFFFFFF, hi=0.
- MTHI 0xA5 with mem_allowin=0 for 5 cycles → out_valid held 5 cycles, hi unchanged; hi=0xA5 the cycle after mem_allowin rises. A back-to-back MTLO stream commits 1 per cycle.
- DIVU started, flush asserted on cycle 10 → no commit, HI/LO keep prior values, allowin=1 the next cycle. The next MULT completes normally.
- MULT with ex_block=1 at the commit edge → out_valid handshake completes, HI/LO unchanged. rst asserted mid-DIV → hi=lo=0, state IDLE next cycle.

Source files
------------

// File: rtl/pipe_exe_muldiv.sv
// EXE-stage multiply/divide unit with architectural HI/LO registers.
// Holds the stage while a pipelined multiply or restoring divide runs; commits HI/LO on retire.
module pipe_exe_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             allowin_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ex_block_i,
  input  logic             flush_i,
  input  logic             mem_allowin_i,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam int unsigned CntMax = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            op_q;
  logic [WIDTH-1:0]      a_q, b_q;
  logic [WIDTH-1:0]      quo_q, quo_d, rem_q, rem_d, bmag_q, bmag_d;
  logic [2*WIDTH-1:0]    prod_q [MUL_LAT];
  logic [WIDTH-1:0]      hi_q, lo_q;

  logic                  accept, commit;
  logic [2*WIDTH-1:0]    mul_a, mul_b, product;
  logic                  sdiv_in, sdiv_q, q_neg, r_neg;
  logic [WIDTH-1:0]      a_mag_in, b_mag_in;
  logic [WIDTH:0]        rem_shift, diff;
  logic [WIDTH-1:0]      res_hi, res_lo;
  logic                  wr_hi, wr_lo;

  function automatic state_e op_state(input logic [2:0] op);
    if (op == OpMult || op == OpMultu) return StMul;
    if (op == OpDiv || op == OpDivu) return StDiv;
    return StDone;
  endfunction

  always_comb begin
    out_valid_o = (state_q == StDone);
    busy_o      = (state_q == StMul) || (state_q == StDiv);
    allowin_o   = ((state_q == StIdle) || (out_valid_o && mem_allowin_i)) && !flush_i;
    accept      = in_valid_i && allowin_o;
    commit      = out_valid_o && mem_allowin_i && !flush_i;
    hi_o        = hi_q;
    lo_o        = lo_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) state_d = op_state(op_i);
          cnt_d = '0;
        end
        StMul: begin
          if (cnt_q == CntW'(MUL_LAT - 1)) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDiv: begin
          if (cnt_q == CntW'(WIDTH)) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (commit) state_d = accept ? op_state(op_i) : StIdle;
          cnt_d = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sign- or zero-extend to 2*WIDTH so one truncated multiply serves both MULT and MULTU.
  always_comb begin
    mul_a   = (op_q == OpMult) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_b   = (op_q == OpMult) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = mul_a * mul_b;
  end

  always_comb begin
    sdiv_in   = (op_i == OpDiv);
    a_mag_in  = (sdiv_in && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag_in  = (sdiv_in && b_i[WIDTH-1]) ? -b_i : b_i;
    sdiv_q    = (op_q == OpDiv);
    q_neg     = sdiv_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg     = sdiv_q && a_q[WIDTH-1];
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, bmag_q};
    quo_d     = quo_q;
    rem_d     = rem_q;
    bmag_d    = bmag_q;
    if (accept && (op_state(op_i) == StDiv)) begin
      quo_d  = a_mag_in;
      rem_d  = '0;
      bmag_d = b_mag_in;
    end else if (state_q == StDiv) begin
      if (cnt_q < CntW'(WIDTH)) begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end else if (b_q == '0) begin
        // Divide by zero yields an all-ones quotient and the raw dividend, signed or not.
        quo_d = '1;
        rem_d = a_q;
      end else begin
        quo_d = q_neg ? -quo_q : quo_q;
        rem_d = r_neg ? -rem_q : rem_q;
      end
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    unique case (op_q)
      OpMult, OpMultu: begin
        res_hi = prod_q[MUL_LAT-1][2*WIDTH-1:WIDTH];
        res_lo = prod_q[MUL_LAT-1][WIDTH-1:0];
        wr_hi  = 1'b1;
        wr_lo  = 1'b1;
      end
      OpDiv, OpDivu: begin
        res_hi = rem_q;
        res_lo = quo_q;
        wr_hi  = 1'b1;
        wr_lo  = 1'b1;
      end
      OpMthi: begin
        res_hi = a_q;
        wr_hi  = 1'b1;
      end
      OpMtlo: begin
        res_lo = a_q;
        wr_lo  = 1'b1;
      end
      default: begin
        wr_hi = 1'b0;
        wr_lo = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      if (accept) begin
        op_q <= op_i;
        a_q  <= a_i;
        b_q  <= b_i;
      end
      if (commit && !ex_block_i && wr_hi) hi_q <= res_hi;
      if (commit && !ex_block_i && wr_lo) lo_q <= res_lo;
    end
  end

  // Shifts only while in MUL, so the last stage holds the product throughout DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MUL_LAT); i++) prod_q[i] <= '0;
    end else if (state_q == StMul) begin
      prod_q[0] <= product;
      for (int i = 1; i < int'(MUL_LAT); i++) prod_q[i] <= prod_q[i-1];
    end
  end

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Self-checking bench for pipe_exe_muldiv: directed spec cases plus randomized ops
// checked against an arithmetic HI/LO reference model.
module tb_pipe_exe_muldiv;

  localparam int unsigned W = 32;
  localparam int unsigned L = 2;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic         clk = 1'b0;
  logic         rst, in_valid, ex_block, flush, mem_allowin;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         allowin, out_valid, busy;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  pipe_exe_muldiv #(.WIDTH(W), .MUL_LAT(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .allowin_o    (allowin),
    .op_i         (op),
    .a_i          (a),
    .b_i          (b),
    .ex_block_i   (ex_block),
    .flush_i      (flush),
    .mem_allowin_i(mem_allowin),
    .out_valid_o  (out_valid),
    .busy_o       (busy),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Architectural effect of one retired op, from the ISA rules.
  function automatic void model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                input logic exb);
    logic [63:0] p;
    int          sa, sb;
    logic [31:0] q, r;
    sa = ma;
    sb = mb;
    q  = exp_lo;
    r  = exp_hi;
    case (mop)
      OpMult:  begin p = longint'(sa) * longint'(sb); r = p[63:32]; q = p[31:0]; end
      OpMultu: begin p = {32'd0, ma} * {32'd0, mb}; r = p[63:32]; q = p[31:0]; end
      OpDiv: begin
        if (mb == 0) begin q = '1; r = ma; end
        else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin q = ma; r = 0; end
        else begin q = sa / sb; r = sa % sb; end
      end
      OpDivu: begin
        if (mb == 0) begin q = '1; r = ma; end
        else begin q = ma / mb; r = ma % mb; end
      end
      OpMthi:  r = ma;
      OpMtlo:  q = ma;
      default: ;
    endcase
    if (!exb) begin
      exp_hi = r;
      exp_lo = q;
    end
  endfunction

  task automatic run_op(input string tag, input logic [2:0] top, input logic [31:0] ta,
                        input logic [31:0] tb, input logic exb, input int stall);
    int           lat, busy_n, lowin_n, exp_lat;
    logic [W-1:0] hold_hi, hold_lo;
    bit           done;
    exp_lat = (top == OpMult || top == OpMultu) ? int'(L) :
              (top == OpDiv || top == OpDivu) ? int'(W) + 1 : 0;
    @(negedge clk);
    in_valid    = 1'b1;
    op          = top;
    a           = ta;
    b           = tb;
    ex_block    = exb;
    mem_allowin = (stall == 0);
    hold_hi     = hi;
    hold_lo     = lo;
    #1 check({tag, "_allowin"}, allowin, 1);
    @(posedge clk);
    lat = 0; busy_n = 0; lowin_n = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat++;
      if (busy) busy_n++;
      if (busy && !allowin) lowin_n++;
      if (out_valid) done = 1;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, lat - 1, exp_lat);
    check({tag, "_busy"}, busy_n, exp_lat);
    check({tag, "_allowin_low"}, lowin_n, exp_lat);
    check({tag, "_hi_held"}, hi, hold_hi);
    for (int s = 0; s < stall; s++) begin
      if (s > 0) begin
        @(negedge clk);
        #1;
      end
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_hi"}, hi, hold_hi);
      check({tag, "_stall_lo"}, lo, hold_lo);
    end
    mem_allowin = 1'b1;
    @(posedge clk);
    model(top, ta, tb, exb);
    @(negedge clk);
    ex_block = 1'b0;
    #1;
    check({tag, "_retired"}, out_valid, 0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    logic [W-1:0] vals [6];
    logic [W-1:0] hold_hi, hold_lo;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; ex_block = 1'b0; flush = 1'b0; mem_allowin = 1'b1;
    op = OpNop; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_allowin", allowin, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);

    run_op("mult", OpMult, 32'hFFFF_FFFD, 32'd5, 1'b0, 0);
    check("mult_hi_lit", hi, 32'hFFFF_FFFF);
    check("mult_lo_lit", lo, 32'hFFFF_FFF1);
    run_op("multu", OpMultu, 32'hFFFF_FFFD, 32'd5, 1'b0, 0);
    check("multu_hi_lit", hi, 32'h0000_0004);
    run_op("divu", OpDivu, 32'd100, 32'd7, 1'b0, 0);
    check("divu_lo_lit", lo, 32'd14);
    run_op("div_neg", OpDiv, -32'sd7, 32'd2, 1'b0, 0);
    check("div_neg_lo_lit", lo, 32'hFFFF_FFFD);
    run_op("div_min", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    check("div_min_lo_lit", lo, 32'h8000_0000);
    run_op("div_zero", OpDiv, 32'h1234, 32'd0, 1'b0, 0);
    check("div_zero_hi_lit", hi, 32'h1234);
    run_op("divu_zero", OpDivu, 32'd0, 32'd0, 1'b0, 0);
    check("divu_zero_lo_lit", lo, 32'hFFFF_FFFF);
    run_op("mthi_stall", OpMthi, 32'hA5, 32'd0, 1'b0, 5);
    check("mthi_hi_lit", hi, 32'hA5);
    run_op("nop", OpNop, 32'h55, 32'h66, 1'b0, 1);

    // Back-to-back MTLO stream: one commit per cycle.
    for (int i = 0; i < 6; i++) vals[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = OpMtlo; a = vals[i]; mem_allowin = 1'b1;
      #1;
      check("stream_allowin", allowin, 1);
      if (i >= 1) check("stream_valid", out_valid, 1);
      if (i >= 2) check("stream_lo", lo, vals[i-2]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("stream_lo_tail", lo, vals[4]);
    @(negedge clk);
    #1;
    check("stream_lo_last", lo, vals[5]);
    check("stream_idle", out_valid, 0);
    exp_lo = vals[5];

    // Flush a DIVU on its tenth cycle.
    @(negedge clk);
    in_valid = 1'b1; op = OpDivu; a = 32'd999; b = 32'd3;
    hold_hi = hi; hold_lo = lo;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_allowin_low", allowin, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_allowin", allowin, 1);
    check("flush_busy", busy, 0);
    check("flush_valid", out_valid, 0);
    check("flush_hi", hi, hold_hi);
    check("flush_lo", lo, hold_lo);
    run_op("mult_after_flush", OpMult, 32'd12345, -32'sd678, 1'b0, 0);

    run_op("mult_exb", OpMult, 32'd7, 32'd9, 1'b1, 0);
    check("mult_exb_lo", lo, hold_lo == 32'd63 ? 32'd62 : exp_lo);

    // Randomized ops against the reference model.
    for (int n = 0; n < 24; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 300));
        default: rb = 32'($urandom);
      endcase
      run_op("rand", rop, ra, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 2));
    end

    // Reset in the middle of a DIV clears HI/LO.
    @(negedge clk);
    in_valid = 1'b1; op = OpDiv; a = 32'd5000; b = 32'd17;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_allowin", allowin, 1);
    exp_hi = '0;
    exp_lo = '0;
    run_op("mult_after_rst", OpMultu, 32'hDEAD_BEEF, 32'h1000, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
